// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: shared state encoding and default sizes for the fabric configuration loader.
package fpga_cfg_pkg;
    localparam int CFG_WORD_W    = 224;
    localparam int CFG_NUM_WORDS = 43;
    localparam int CFG_SETTLE    = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_SETTLE,
        S_FFEN,
        S_DONE
    } cfg_state_t;
endpackage

// File: rtl/cfg_settle_timer.sv
// cfg_settle_timer: loadable down-counter; done is high while enabled and the count has reached zero.
//   clock, rst_n : clock and asynchronous active-low reset
//   load         : load load_val into the counter (has priority over counting)
//   load_val     : value to load
//   en           : count down while nonzero
//   done         : en && count == 0
module cfg_settle_timer #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);
    logic [W-1:0] cnt;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en && cnt != '0) cnt <= cnt - W'(1);
    end

    assign done = en && cnt == '0;
endmodule

// File: rtl/fpga_config_loader.sv
// fpga_config_loader: streams configuration words into the fabric, then enables its flip-flops.
//   clock, rst_n          : clock and asynchronous active-low reset
//   start                 : begin a pass (honoured only when idle or done)
//   cfg_data/valid/ready  : incoming word stream, word 0 first
//   configs_in            : registered word presented to the fabric
//   configs_en            : one-hot slot write strobe
//   ff_en, rdy, busy      : fabric flip-flop enable, pass complete, pass in progress
module fpga_config_loader
    import fpga_cfg_pkg::*;
#(
    parameter int WORD_W        = CFG_WORD_W,
    parameter int NUM_WORDS     = CFG_NUM_WORDS,
    parameter int SETTLE_CYCLES = CFG_SETTLE
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WORD_W-1:0]    cfg_data,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic [WORD_W-1:0]    configs_in,
    output logic [NUM_WORDS-1:0] configs_en,
    output logic                 ff_en,
    output logic                 rdy,
    output logic                 busy
);
    localparam int IDX_W = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
    localparam int CNT_W = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;

    cfg_state_t       state, state_nx;
    logic [IDX_W-1:0] idx;
    logic             last, settle_done;

    assign last = idx == IDX_W'(NUM_WORDS - 1);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            configs_in <= '0;
        end else begin
            state <= state_nx;
            if (state == S_WRITE && !last) idx <= idx + IDX_W'(1);
            else if (start && (state == S_IDLE || state == S_DONE)) idx <= '0;
            if (cfg_valid && cfg_ready) configs_in <= cfg_data;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: state_nx = start ? S_LOAD : state;
            S_LOAD:         state_nx = cfg_valid ? S_WRITE : S_LOAD;
            S_WRITE:        state_nx = last ? S_SETTLE : S_LOAD;
            S_SETTLE:       state_nx = settle_done ? S_FFEN : S_SETTLE;
            S_FFEN:         state_nx = S_DONE;
            default:        state_nx = S_IDLE;
        endcase
        cfg_ready  = state == S_LOAD;
        configs_en = state == S_WRITE ? NUM_WORDS'(1) << idx : '0;
        ff_en      = state == S_FFEN || state == S_DONE;
        rdy        = state == S_DONE;
        busy       = !(state == S_IDLE || state == S_DONE);
    end

    // Loaded on the last write so the count of SETTLE cycles is exactly SETTLE_CYCLES.
    cfg_settle_timer #(.W(CNT_W)) u_settle (
        .clock    (clock),
        .rst_n    (rst_n),
        .load     (state == S_WRITE && last),
        .load_val (CNT_W'(SETTLE_CYCLES - 1)),
        .en       (state == S_SETTLE),
        .done     (settle_done)
    );
endmodule

// File: tb/tb_fpga_config_loader.sv
// tb_fpga_config_loader: rule-based self-checking bench for the configuration loader.
module tb_fpga_config_loader;
    localparam int N = 3;
    localparam int S = 4;

    logic       clock = 0;
    logic       rst_n = 0;
    logic       start = 0;
    logic       cfg_valid = 0;
    logic [7:0] cfg_data = 0;
    logic       cfg_ready, ff_en, rdy, busy;
    logic [7:0] configs_in;
    logic [2:0] configs_en;

    logic       start1 = 0, valid1 = 0;
    logic [7:0] data1 = 0;
    logic       ready1, ff1, rdy1, busy1;
    logic [7:0] cin1;
    logic [0:0] cen1;

    int checks = 0;
    int errors = 0;

    logic [7:0] stream[$];
    int         gaps[$];
    logic [7:0] model_cfg_in = 0;

    always #5 clock = ~clock;

    fpga_config_loader #(.WORD_W(8), .NUM_WORDS(N), .SETTLE_CYCLES(S)) dut (
        .clock(clock), .rst_n(rst_n), .start(start), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .configs_in(configs_in), .configs_en(configs_en),
        .ff_en(ff_en), .rdy(rdy), .busy(busy)
    );

    fpga_config_loader #(.WORD_W(8), .NUM_WORDS(1), .SETTLE_CYCLES(1)) dut1 (
        .clock(clock), .rst_n(rst_n), .start(start1), .cfg_data(data1), .cfg_valid(valid1),
        .cfg_ready(ready1), .configs_in(cin1), .configs_en(cen1),
        .ff_en(ff1), .rdy(rdy1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, cfg_ready, 0);
        chk({tag, "_cin"}, configs_in, 0);
        chk({tag, "_cen"}, configs_en, 0);
        chk({tag, "_ffen"}, ff_en, 0);
        chk({tag, "_rdy"}, rdy, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Queue words (and per-word valid-low gaps) for the next pass.
    task automatic load_words(input int n, input int gap_lo, input int gap_hi);
        for (int i = 0; i < n; i++) begin
            stream.push_back(8'($urandom));
            gaps.push_back(int'($urandom_range(gap_hi, gap_lo)));
        end
    endtask

    // One pass: start pulse, then per-cycle checks derived from the stream rules
    // until rdy is due. Returns with the DUT in DONE (or after a timeout).
    task automatic run_pass(input string tag, input bit poke_start);
        int cyc, acc, w, g;
        bit hs, hs_prev, exp_ready, exp_ff, exp_rdy, finished;
        start = 1;
        tick;
        cyc = 1; acc = 0; w = -1; hs_prev = 0; finished = 0;
        g = gaps.size() > 0 ? gaps.pop_front() : 0;
        while (!finished && cyc < 400) begin
            exp_ready = !hs_prev && acc < N;
            if (stream.size() > 0 && g == 0) begin
                cfg_valid = 1;
                cfg_data  = stream[0];
            end else begin
                cfg_valid = 0;
                cfg_data  = 8'($urandom);
                if (stream.size() > 0) g--;
            end
            start = poke_start && w >= 0 && cyc == w + 2;
            exp_ff  = w >= 0 && cyc >= w + S + 1;
            exp_rdy = w >= 0 && cyc >= w + S + 2;
            chk({tag, "_cfg_ready"}, cfg_ready, exp_ready);
            chk({tag, "_configs_en"}, configs_en, hs_prev ? 64'(1) << (acc - 1) : 64'd0);
            chk({tag, "_configs_in"}, configs_in, model_cfg_in);
            chk({tag, "_ff_en"}, ff_en, exp_ff);
            chk({tag, "_rdy"}, rdy, exp_rdy);
            chk({tag, "_busy"}, busy, !exp_rdy);
            if (hs_prev && acc == N) w = cyc;
            hs = cfg_valid && exp_ready;
            if (hs) begin
                model_cfg_in = stream.pop_front();
                acc++;
                g = gaps.size() > 0 ? gaps.pop_front() : 0;
            end
            hs_prev = hs;
            if (exp_rdy) finished = 1;
            else begin
                tick;
                cyc++;
            end
        end
        if (!finished) chk({tag, "_timeout_rdy"}, rdy, 1);
        start = 0;
        cfg_valid = 0;
        stream.delete();
        gaps.delete();
    endtask

    initial begin
        #2;
        chk_all_zero("reset");
        chk("reset1_cen", cen1, 0);
        chk("reset1_ffen", ff1, 0);
        @(negedge clock);
        rst_n = 1;
        tick;

        stream = '{8'hA1, 8'hB2, 8'hC3};
        gaps   = '{0, 0, 0};
        run_pass("basic", 0);

        stream = '{8'h11, 8'h22, 8'h33};
        gaps   = '{0, 0, 0};
        run_pass("reconfig", 0);

        stream = '{8'hA1, 8'hB2, 8'hC3};
        gaps   = '{3, 3, 3};
        run_pass("gaps", 0);

        load_words(5, 0, 0);
        run_pass("extra", 0);

        load_words(3, 0, 2);
        run_pass("settle_start", 1);

        start = 1;
        tick;
        start = 0;
        cfg_valid = 1;
        cfg_data = 8'h3C;
        tick;
        cfg_valid = 0;
        tick;
        cfg_valid = 1;
        cfg_data = 8'h4D;
        #2;
        rst_n = 0;
        #1;
        chk_all_zero("midreset");
        cfg_valid = 0;
        model_cfg_in = 0;
        @(negedge clock);
        rst_n = 1;
        tick;
        chk("post_reset_busy", busy, 0);
        chk("post_reset_ready", cfg_ready, 0);
        load_words(3, 0, 1);
        run_pass("fresh", 0);

        for (int i = 0; i < 5; i++) begin
            load_words(3 + int'($urandom_range(2, 0)), 0, 4);
            run_pass("random", 0);
        end

        start1 = 1;
        tick;
        start1 = 0;
        valid1 = 1;
        data1 = 8'h5A;
        chk("edge_ready", ready1, 1);
        chk("edge_cen_load", cen1, 0);
        tick;
        valid1 = 0;
        chk("edge_cen_write", cen1, 1);
        chk("edge_cin", cin1, 8'h5A);
        chk("edge_ready_write", ready1, 0);
        tick;
        chk("edge_cen_settle", cen1, 0);
        chk("edge_ff_settle", ff1, 0);
        chk("edge_busy_settle", busy1, 1);
        tick;
        chk("edge_ff", ff1, 1);
        chk("edge_rdy_early", rdy1, 0);
        tick;
        chk("edge_rdy", rdy1, 1);
        chk("edge_ff_done", ff1, 1);
        chk("edge_busy_done", busy1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
